// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b shared types for the memory-access stage
package lc3b_types;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_byte;
    logic mem_indirect;
  } lc3b_control_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } lc3b_mem_state_t;

  function automatic logic [15:0] word_addr(input logic [15:0] a);
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_byte_align.sv
// rtl/mem_byte_align.sv - load lane select/sign-extend and store lane replication
module mem_byte_align (
  input  logic        addr_lsb,
  input  logic        is_byte,
  input  logic [15:0] rdata,
  input  logic [15:0] store_data,
  output logic [15:0] load_data,
  output logic [15:0] wdata,
  output logic [1:0]  byte_enable
);

  logic [7:0] lane;

  assign lane        = addr_lsb ? rdata[15:8] : rdata[7:0];
  assign load_data   = is_byte ? {{8{lane[7]}}, lane} : rdata;
  assign wdata       = is_byte ? {2{store_data[7:0]}} : store_data;
  assign byte_enable = is_byte ? (addr_lsb ? 2'b10 : 2'b01) : 2'b11;

endmodule

// File: rtl/stage_mem_access.sv
// rtl/stage_mem_access.sv - LC-3b memory-access stage; STAGE_MEM_INDIRECT_EN enables LDI/STI two-phase access
module stage_mem_access
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_in,
  input  lc3b_control_word control_in,
  input  logic [15:0]      alu_in,
  input  logic [15:0]      store_data_in,
  output logic [15:0]      dmem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [1:0]       dmem_byte_enable,
  output logic [15:0]      dmem_wdata,
  input  logic [15:0]      dmem_rdata,
  input  logic             dmem_resp,
  output logic [15:0]      mem_data_out,
  output logic             mem_stall_out
);

  lc3b_mem_state_t state;

  logic        is_read_q, is_write_q, is_byte_q, indirect_q, addr_lsb_q;
  logic [15:0] store_data_q;
  logic        req_read, req_write, req_byte, req_indirect;
  logic        align_lsb, align_byte;
  logic [15:0] load_data, st_wdata;
  logic [1:0]  st_be;

  // Read+write together is an illegal encoding and resolves to a write.
  always_comb begin
    req_write = control_in.mem_write;
    req_read  = control_in.mem_read & ~control_in.mem_write;
`ifdef STAGE_MEM_INDIRECT_EN
    req_indirect = control_in.mem_indirect;
`else
    req_indirect = control_in.mem_indirect & 1'b0;
`endif
    req_byte = control_in.mem_byte & ~req_indirect;
  end

  // Store side is only consumed in IDLE; load side uses the latched lane.
  assign align_lsb  = (state == IDLE) ? alu_in[0] : addr_lsb_q;
  assign align_byte = (state == IDLE) ? req_byte  : is_byte_q;

  mem_byte_align u_align (
    .addr_lsb    (align_lsb),
    .is_byte     (align_byte),
    .rdata       (dmem_rdata),
    .store_data  (store_data_in),
    .load_data   (load_data),
    .wdata       (st_wdata),
    .byte_enable (st_be)
  );

  always_comb begin
    mem_stall_out = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:       mem_stall_out = req_read | req_write;
        ACC1, ACC2: mem_stall_out = 1'b1;
        default:    mem_stall_out = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      dmem_address     <= '0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_byte_enable <= '0;
      dmem_wdata       <= '0;
      mem_data_out     <= '0;
      is_read_q        <= 1'b0;
      is_write_q       <= 1'b0;
      is_byte_q        <= 1'b0;
      indirect_q       <= 1'b0;
      addr_lsb_q       <= 1'b0;
      store_data_q     <= '0;
    end else begin
      case (state)
        IDLE: if (req_read || req_write) begin
          state            <= ACC1;
          is_read_q        <= req_read;
          is_write_q       <= req_write;
          is_byte_q        <= req_byte;
          indirect_q       <= req_indirect;
          addr_lsb_q       <= alu_in[0];
          store_data_q     <= store_data_in;
          dmem_address     <= req_byte ? alu_in : word_addr(alu_in);
          // Indirect ops always start with a word read of the pointer.
          dmem_read        <= req_read | req_indirect;
          dmem_write       <= req_write & ~req_indirect;
          dmem_byte_enable <= st_be;
          dmem_wdata       <= st_wdata;
        end
        ACC1: if (dmem_resp) begin
          if (indirect_q) begin
            state            <= ACC2;
            dmem_address     <= word_addr(dmem_rdata);
            dmem_read        <= is_read_q;
            dmem_write       <= is_write_q;
            dmem_byte_enable <= 2'b11;
            dmem_wdata       <= store_data_q;
          end else begin
            state      <= DONE;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (is_read_q) mem_data_out <= load_data;
          end
        end
        ACC2: if (dmem_resp) begin
          state      <= DONE;
          dmem_read  <= 1'b0;
          dmem_write <= 1'b0;
          if (is_read_q) mem_data_out <= dmem_rdata;
        end
        DONE: if (!stall_in) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
